// File: rtl/vedic_pkg.sv
// Shared widths and types for the Vedic multiplier family.
package vedic_pkg;

  localparam int VEDIC_W    = 12;
  localparam int VEDIC_HALF = 6;
  localparam int VEDIC_PW   = 24;

  typedef logic [VEDIC_W-1:0]      operand_t;
  typedef logic [VEDIC_PW-1:0]     product_t;
  typedef logic [VEDIC_HALF-1:0]   half_t;
  typedef logic [2*VEDIC_HALF-1:0] half_prod_t;

endpackage

// File: rtl/vedic_6.sv
// Combinational 6x6 -> 12 Vedic multiplier built from four 3x3 crosswise products.
module vedic_6
  import vedic_pkg::*;
(
  input  half_t      a,
  input  half_t      b,
  output half_prod_t p
);

  // 3x3 Urdhva product: each column collects the vertical/crosswise bit products.
  function automatic logic [5:0] mul3(input logic [2:0] x, input logic [2:0] y);
    logic [5:0] c0, c1, c2, c3, c4;
    c0 = 6'(x[0] & y[0]);
    c1 = 6'(x[1] & y[0]) + 6'(x[0] & y[1]);
    c2 = 6'(x[2] & y[0]) + 6'(x[1] & y[1]) + 6'(x[0] & y[2]);
    c3 = 6'(x[2] & y[1]) + 6'(x[1] & y[2]);
    c4 = 6'(x[2] & y[2]);
    return c0 + (c1 << 1) + (c2 << 2) + (c3 << 3) + (c4 << 4);
  endfunction

  logic [5:0]  p_ll, p_hl, p_lh, p_hh;
  logic [6:0]  mid;

  always_comb begin
    p_ll = mul3(a[2:0], b[2:0]);
    p_hl = mul3(a[5:3], b[2:0]);
    p_lh = mul3(a[2:0], b[5:3]);
    p_hh = mul3(a[5:3], b[5:3]);
    mid  = 7'(p_hl) + 7'(p_lh);
    p    = half_prod_t'(p_ll) + half_prod_t'({mid, 3'b000}) + {p_hh, 6'b000000};
  end

endmodule

// File: rtl/vedic_12_mult.sv
// Registered 12x12 -> 24 unsigned Vedic multiplier; one cycle latency, one pair per cycle.
module vedic_12_mult
  import vedic_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     in_valid,
  input  operand_t a,
  input  operand_t b,
  output product_t p,
  output logic     out_valid
);

  half_prod_t p_ll, p_hl, p_lh, p_hh;
  logic [2*VEDIC_HALF:0] mid;
  product_t sum;

  vedic_6 u_ll (.a(a[VEDIC_HALF-1:0]),       .b(b[VEDIC_HALF-1:0]),       .p(p_ll));
  vedic_6 u_hl (.a(a[VEDIC_W-1:VEDIC_HALF]), .b(b[VEDIC_HALF-1:0]),       .p(p_hl));
  vedic_6 u_lh (.a(a[VEDIC_HALF-1:0]),       .b(b[VEDIC_W-1:VEDIC_HALF]), .p(p_lh));
  vedic_6 u_hh (.a(a[VEDIC_W-1:VEDIC_HALF]), .b(b[VEDIC_W-1:VEDIC_HALF]), .p(p_hh));

  // The crosswise middle sum keeps its 13th bit before being shifted into place.
  always_comb begin
    mid = (2*VEDIC_HALF+1)'(p_hl) + (2*VEDIC_HALF+1)'(p_lh);
    sum = product_t'(p_ll)
        + product_t'({mid, {VEDIC_HALF{1'b0}}})
        + {p_hh, {VEDIC_W{1'b0}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p         <= '0;
      out_valid <= 1'b0;
    end else begin
      p         <= sum;
      out_valid <= in_valid;
    end
  end

endmodule

// File: tb/tb_vedic_12_mult.sv
// Self-checking bench for vedic_12_mult against a plain a*b reference.
module tb_vedic_12_mult;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [11:0] a;
  logic [11:0] b;
  logic [23:0] p;
  logic        out_valid;

  int vector_count;
  int miscompare_count;

  vedic_12_mult dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .a(a),
    .b(b),
    .p(p),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [23:0] observed,
                             input logic [23:0] expected);
    vector_count++;
    if (observed !== expected) begin
      miscompare_count++;
      $display("[TB] FAIL %s: got %0d (0x%06h), expected %0d (0x%06h)",
               tag, observed, observed, expected, expected);
    end
  endtask

  // Drives one operand pair for one clock and checks the registered result.
  task automatic applyStimulus(input string tag, input logic v,
                               input logic [11:0] x, input logic [11:0] y);
    logic [23:0] ref_p;
    in_valid = v;
    a = x;
    b = y;
    ref_p = 24'(x) * 24'(y);
    @(posedge clk);
    #1;
    checkOutput({tag, ".p"}, p, ref_p);
    checkOutput({tag, ".vld"}, 24'(out_valid), 24'(v));
  endtask

  initial begin
    vector_count = 0;
    miscompare_count = 0;
    rst = 1'b1;
    in_valid = 1'b1;
    a = 12'hFFF;
    b = 12'hFFF;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_hold.p", p, 24'd0);
    checkOutput("reset_hold.vld", 24'(out_valid), 24'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("pre_first_edge.p", p, 24'd0);
    checkOutput("pre_first_edge.vld", 24'(out_valid), 24'd0);

    applyStimulus("id_1x0", 1'b1, 12'd1, 12'd0);
    applyStimulus("id_4095x1", 1'b1, 12'd4095, 12'd1);
    applyStimulus("id_1x4095", 1'b1, 12'd1, 12'd4095);
    applyStimulus("max", 1'b1, 12'hFFF, 12'hFFF);
    checkOutput("max_const", p, 24'hFFE001);
    applyStimulus("pow2", 1'b1, 12'd2048, 12'd2048);
    checkOutput("pow2_const", p, 24'h400000);
    applyStimulus("cross", 1'b1, 12'd63, 12'd4032);
    checkOutput("cross_const", p, 24'd254016);

    applyStimulus("stream0", 1'b1, 12'd3, 12'd5);
    applyStimulus("stream1", 1'b1, 12'd100, 12'd200);
    applyStimulus("stream2", 1'b1, 12'd4095, 12'd2);

    applyStimulus("gate0", 1'b1, 12'd7, 12'd9);
    applyStimulus("gate1", 1'b0, 12'd11, 12'd13);
    applyStimulus("gate2", 1'b1, 12'd17, 12'd19);

    // Asynchronous reset in the middle of a cycle with a big product in flight.
    applyStimulus("pre_rst", 1'b1, 12'hFFF, 12'hFFF);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("async_rst.p", p, 24'd0);
    checkOutput("async_rst.vld", 24'(out_valid), 24'd0);
    @(posedge clk);
    #1;
    checkOutput("rst_edge.p", p, 24'd0);
    checkOutput("rst_edge.vld", 24'(out_valid), 24'd0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("rst_release.p", p, 24'd0);
    checkOutput("rst_release.vld", 24'(out_valid), 24'd0);
    applyStimulus("post_rst", 1'b0, 12'd21, 12'd23);

    for (int i = 0; i < 3000; i++) begin
      logic [11:0] ra, rb;
      logic        rv;
      case ($urandom_range(0, 7))
        0:       ra = 12'hFFF;
        1:       ra = 12'd0;
        default: ra = 12'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 12'hFFF;
        1:       rb = 12'($urandom_range(0, 63)) << 6;
        default: rb = 12'($urandom);
      endcase
      rv = ($urandom_range(0, 3) != 0);
      applyStimulus("random", rv, ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
    $finish;
  end

endmodule
